// File: rtl/switch_in_pio_pkg.sv
// rtl/switch_in_pio_pkg.sv - register map and mode constants for the switch input PIO
package switch_in_pio_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   localparam int IRQ_LEVEL = 0;
   localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_input_sync.sv
// rtl/pio_input_sync.sv - input synchronizer, previous-sample register and edge detect
module pio_input_sync
   import switch_in_pio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port_i,
   output logic [WIDTH-1:0] in_sync_o,
   output logic [WIDTH-1:0] edge_o
);

   // sync_q[0] is the first stage; the oldest stage is the synchronized value
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in_port_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign in_sync_o = sync_q[SYNC_STAGES-1];

   generate
      if (EDGE_TYPE == EDGE_RISE) begin : g_rise
         assign edge_o = in_sync_o & ~prev_q;
      end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
         assign edge_o = ~in_sync_o & prev_q;
      end else begin : g_any
         assign edge_o = in_sync_o ^ prev_q;
      end
   endgenerate

endmodule

// File: rtl/switch_in_pio.sv
// rtl/switch_in_pio.sv - Avalon-MM input PIO with edge capture and maskable interrupt
module switch_in_pio
   import switch_in_pio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISE,
   parameter int IRQ_TYPE    = IRQ_EDGE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] capture_q, capture_d;
   logic [WIDTH-1:0] clr;
   logic [31:0]      readdata_q, readdata_d;
   logic             wr_en;

   pio_input_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_port_i (in_port),
      .in_sync_o (in_sync),
      .edge_o    (edge_det)
   );

   generate
      if (WIDTH < 32) begin : g_wd_unused
         logic wd_unused;
         assign wd_unused = ^writedata[31:WIDTH];
      end
   endgenerate

   assign wr_en = chipselect & ~write_n;

   always_comb begin
      mask_d     = mask_q;
      clr        = '0;
      readdata_d = '0;
      if (wr_en && address == ADDR_MASK) mask_d = writedata[WIDTH-1:0];
      if (wr_en && address == ADDR_EDGE) clr = writedata[WIDTH-1:0];
      // a fresh edge outranks a simultaneous clear of the same bit
      capture_d = edge_det | (capture_q & ~clr);
      case (address)
         ADDR_DATA: readdata_d[WIDTH-1:0] = in_sync;
         ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
         ADDR_EDGE: readdata_d[WIDTH-1:0] = capture_q;
         default:   readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q     <= '0;
         capture_q  <= '0;
         readdata_q <= '0;
      end else begin
         mask_q     <= mask_d;
         capture_q  <= capture_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;

   generate
      if (IRQ_TYPE == IRQ_LEVEL) begin : g_irq_level
         assign irq = |(in_sync & mask_q);
      end else begin : g_irq_edge
         assign irq = |(capture_q & mask_q);
      end
   endgenerate

endmodule

// File: tb/tb_switch_in_pio.sv
// tb/tb_switch_in_pio.sv - self-checking bench for switch_in_pio across edge/irq modes
module tb_switch_in_pio;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [1:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [31:0]      writedata;
   logic [7:0]       in_port;
   logic [2:0][31:0] rd;
   logic [2:0]       irq_w;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // instance 0: rising/edge-irq, 1: any-edge/edge-irq, 2: rising/level-irq
   switch_in_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1)) u_rise (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd[0]), .irq(irq_w[0]));
   switch_in_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_TYPE(1)) u_any (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd[1]), .irq(irq_w[1]));
   switch_in_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(0)) u_lvl (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd[2]), .irq(irq_w[2]));

   // h1/h2/h3: in_port as sampled at the last, second-last and third-last clock edge
   logic [7:0]  h1, h2, h3;
   logic [7:0]  m_mask;
   logic [7:0]  m_cap [3];
   logic [31:0] m_rd  [3];

   function automatic int etype(int k);
      return (k == 1) ? 2 : 0;
   endfunction

   function automatic logic [7:0] edge_of(int t, logic [7:0] cur, logic [7:0] prev);
      case (t)
         0:       return cur & ~prev;
         1:       return ~cur & prev;
         default: return cur ^ prev;
      endcase
   endfunction

   function automatic logic m_irq(int k);
      if (k == 2) return |(h2 & m_mask);
      return |(m_cap[k] & m_mask);
   endfunction

   task automatic model_reset();
      h1 = 8'h00; h2 = 8'h00; h3 = 8'h00; m_mask = 8'h00;
      for (int k = 0; k < 3; k++) begin
         m_cap[k] = 8'h00;
         m_rd[k]  = 32'h0;
      end
   endtask

   task automatic tick();
      logic       wr;
      logic [7:0] clr;
      wr  = chipselect & ~write_n;
      clr = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
      for (int k = 0; k < 3; k++) begin
         case (address)
            2'd0:    m_rd[k] = {24'h0, h2};
            2'd2:    m_rd[k] = {24'h0, m_mask};
            2'd3:    m_rd[k] = {24'h0, m_cap[k]};
            default: m_rd[k] = 32'h0;
         endcase
         m_cap[k] = edge_of(etype(k), h2, h3) | (m_cap[k] & ~clr);
      end
      if (wr && address == 2'd2) m_mask = writedata[7:0];
      h3 = h2; h2 = h1; h1 = in_port;
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      tick();
      bus_idle();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; in_port = 8'h00; address = 2'd0;
      bus_idle();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (rd[k] !== 32'h0 || irq_w[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset dut%0d rd=%h irq=%b expected rd=0 irq=0", k, rd[k], irq_w[k]);
         end
      end
      reset_n = 1'b1;
      repeat (3) begin
         tick();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rd[k] !== m_rd[k] || irq_w[k] !== m_irq(k)) begin
               n_fail++;
               $display("FAIL post_reset dut%0d rd=%h irq=%b expected rd=%h irq=%b", k, rd[k], irq_w[k], m_rd[k], m_irq(k));
            end
         end
      end
   endtask

   task automatic test_data_read();
      in_port = 8'hA5; address = 2'd0;
      repeat (3) tick();
      n_checks++;
      if (rd[0] !== 32'h000000A5) begin
         n_fail++;
         $display("FAIL data_read rd=%h expected 000000a5", rd[0]);
      end
      address = 2'd3;
      tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (rd[k] !== 32'h000000A5 || irq_w[k] !== 1'b0 || rd[k] !== m_rd[k]) begin
            n_fail++;
            $display("FAIL capture_a5 dut%0d rd=%h irq=%b expected rd=000000a5 irq=0", k, rd[k], irq_w[k]);
         end
      end
   endtask

   task automatic test_irq_edge();
      bus_write(2'd3, 32'hFF);
      in_port = 8'hA4;
      repeat (4) tick();
      bus_write(2'd3, 32'hFF);
      bus_write(2'd2, 32'h1);
      tick();
      in_port = 8'hA5;
      for (int c = 1; c <= 3; c++) begin
         tick();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (irq_w[k] !== m_irq(k)) begin
               n_fail++;
               $display("FAIL irq_rise c%0d dut%0d irq=%b expected %b", c, k, irq_w[k], m_irq(k));
            end
         end
         n_checks++;
         if (irq_w[0] !== (c == 3)) begin
            n_fail++;
            $display("FAIL irq_latency c%0d irq=%b expected %b", c, irq_w[0], (c == 3));
         end
      end
      bus_write(2'd3, 32'h1);
      n_checks++;
      if (irq_w[0] !== 1'b0 || irq_w[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_clear irq0=%b irq1=%b expected 0 0", irq_w[0], irq_w[1]);
      end
      address = 2'd3;
      tick();
      n_checks++;
      if (rd[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL capture_cleared rd=%h expected 00000000", rd[0]);
      end
   endtask

   task automatic test_clear_collision();
      in_port = in_port | 8'h08;
      repeat (4) tick();
      in_port = in_port & ~8'h08;
      repeat (4) tick();
      in_port = in_port | 8'h08;
      repeat (2) tick();
      bus_write(2'd3, 32'h8);
      address = 2'd3;
      tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (rd[k][3] !== 1'b1 || rd[k] !== m_rd[k]) begin
            n_fail++;
            $display("FAIL clear_collision dut%0d rd=%h expected %h with bit3 set", k, rd[k], m_rd[k]);
         end
      end
   endtask

   task automatic test_edge_any();
      bus_write(2'd3, 32'hFF);
      in_port = in_port & 8'h7F;
      repeat (4) tick();
      address = 2'd3;
      tick();
      n_checks++;
      if (rd[0] !== 32'h0 || rd[1] !== 32'h80) begin
         n_fail++;
         $display("FAIL edge_any rise=%h any=%h expected 00000000 00000080", rd[0], rd[1]);
      end
   endtask

   task automatic test_level_irq();
      bus_write(2'd3, 32'hFF);
      bus_write(2'd2, 32'h10);
      tick();
      in_port = in_port | 8'h10;
      for (int c = 1; c <= 4; c++) begin
         if (c == 3) in_port = in_port & ~8'h10;
         tick();
         n_checks++;
         if (irq_w[2] !== ((c == 2) || (c == 3)) || irq_w[2] !== m_irq(2)) begin
            n_fail++;
            $display("FAIL level_irq c%0d irq=%b expected %b", c, irq_w[2], ((c == 2) || (c == 3)));
         end
      end
      n_checks++;
      if (irq_w[0] !== 1'b1 || irq_w[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL level_vs_edge edge_irq=%b level_irq=%b expected 1 0", irq_w[0], irq_w[2]);
      end
   endtask

   task automatic test_random();
      repeat (400) begin
         if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
         address    = 2'($urandom_range(0, 3));
         chipselect = 1'($urandom_range(0, 1));
         write_n    = ($urandom_range(0, 2) != 0);
         writedata  = $urandom;
         tick();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rd[k] !== m_rd[k] || irq_w[k] !== m_irq(k)) begin
               n_fail++;
               $display("FAIL random dut%0d rd=%h irq=%b expected rd=%h irq=%b", k, rd[k], irq_w[k], m_rd[k], m_irq(k));
            end
         end
      end
      bus_idle();
   endtask

   task automatic test_reset_mid();
      bus_write(2'd2, 32'hFF);
      in_port = 8'h00;
      repeat (4) tick();
      bus_write(2'd3, 32'hFF);
      in_port = 8'hFF;
      repeat (4) tick();
      address = 2'd3;
      tick();
      n_checks++;
      if (rd[0] !== 32'hFF || irq_w[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset rd=%h irq=%b expected 000000ff 1", rd[0], irq_w[0]);
      end
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (rd[k] !== 32'h0 || irq_w[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset dut%0d rd=%h irq=%b expected rd=0 irq=0", k, rd[k], irq_w[k]);
         end
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
      address = 2'd2;
      tick();
      address = 2'd3;
      tick();
      n_checks++;
      if (rd[0] !== 32'h0 || rd[0] !== m_rd[0]) begin
         n_fail++;
         $display("FAIL reset_mask_capture rd=%h expected 00000000", rd[0]);
      end
      bus_write(2'd1, 32'hFFFFFFFF);
      address = 2'd1;
      tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (rd[k] !== 32'h0 || irq_w[k] !== m_irq(k)) begin
            n_fail++;
            $display("FAIL addr1 dut%0d rd=%h irq=%b expected rd=0 irq=%b", k, rd[k], irq_w[k], m_irq(k));
         end
      end
      repeat (4) begin
         address = 2'd3;
         tick();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rd[k] !== m_rd[k] || irq_w[k] !== m_irq(k)) begin
               n_fail++;
               $display("FAIL resample dut%0d rd=%h irq=%b expected rd=%h irq=%b", k, rd[k], irq_w[k], m_rd[k], m_irq(k));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_data_read();
      test_irq_edge();
      test_clear_collision();
      test_edge_any();
      test_level_irq();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
